id_ex_stage: RTL and testbench

//  Decode->execute pipeline register directly downstream of the register file.
//  - Captures RD1/RD2 operands plus decoded fields each cycle.
//  - Applies a writeback bypass, because the register file write is not visible on same-cycle reads.
//  - Detects load-use hazards.
//  - Supports stall (hold) and flush (bubble).

---
 rtl/id_ex_stage_pkg.sv | 17 +
 rtl/id_ex_stage_if.sv | 67 ++++++
 rtl/id_ex_stage_wb_bypass_mux.sv | 31 +++
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_pkg
// Brief   : Shared widths and constants for the ID->EX pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

  localparam int XLEN   = 32;  // operand / immediate / PC width
  localparam int REG_AW = 5;   // register address width
  localparam int CTRL_W = 12;  // opaque control bundle width

  // Architectural zero register; reads always return 0 and writes are ignored.
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_if
// Brief   : Bundle of ID-side, control, writeback and EX-side signals of the
//           ID->EX pipeline register. The master drives ID/WB/control and
//           observes EX; the slave is the stage itself.
// Revision: 1.0 - initial release
// ============================================================================
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  // Decode-slot inputs
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [XLEN-1:0]   id_rd1_i;
  logic [XLEN-1:0]   id_rd2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              id_mem_read_i;
  logic              id_reg_write_i;

  // Pipeline control
  logic              stall_i;
  logic              flush_i;

  // Writeback port (mirrors regfile WE3/A3/WD3)
  logic              wb_we_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic [XLEN-1:0]   wb_data_i;

  // Execute-slot outputs
  logic              ex_valid_o;
  logic [REG_AW-1:0] ex_rs1_o;
  logic [REG_AW-1:0] ex_rs2_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic              ex_mem_read_o;
  logic              ex_reg_write_o;
  logic              load_use_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd1_i, id_rd2_i, id_rd_i,
           id_imm_i, id_pc_i, id_ctrl_i, id_mem_read_i, id_reg_write_i,
           stall_i, flush_i, wb_we_i, wb_rd_i, wb_data_i,
    input  ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_rd_o, ex_imm_o, ex_pc_o, ex_ctrl_o, ex_mem_read_o,
           ex_reg_write_o, load_use_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd1_i, id_rd2_i, id_rd_i,
           id_imm_i, id_pc_i, id_ctrl_i, id_mem_read_i, id_reg_write_i,
           stall_i, flush_i, wb_we_i, wb_rd_i, wb_data_i,
    output ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_rd_o, ex_imm_o, ex_pc_o, ex_ctrl_o, ex_mem_read_o,
           ex_reg_write_o, load_use_o
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_wb_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module  : wb_bypass_mux
// Brief   : Selects the in-flight writeback value over stale register-file
//           data when the writeback targets the same register. Register x0
//           always reads as zero.
// Revision: 1.0 - initial release
// ============================================================================
module wb_bypass_mux
  import id_ex_stage_pkg::*;
(
  input  wire logic [REG_AW-1:0] addr_i,
  input  wire logic [XLEN-1:0]   rf_data_i,
  input  wire logic              wb_we_i,
  input  wire logic [REG_AW-1:0] wb_rd_i,
  input  wire logic [XLEN-1:0]   wb_data_i,
  output logic      [XLEN-1:0]   data_o
);

  // x0 is hardwired; otherwise a matching writeback beats the regfile read.
  always_comb begin
    data_o = rf_data_i;
    if (addr_i == REG_X0) begin
      data_o = '0;
    end else if (wb_we_i && (wb_rd_i != REG_X0) && (wb_rd_i == addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : Decode->execute pipeline register with writeback bypass, held
//           operand refresh during stalls, load-use hazard detection, stall
//           and flush. Priority per edge: reset > flush > stall > load-use
//           bubble > normal load.
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst,   // synchronous, active-low
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q,     ex_valid_d;
  logic [REG_AW-1:0] ex_rs1_q,       ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,       ex_rs2_d;
  logic [XLEN-1:0]   ex_rs1_data_q,  ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q,  ex_rs2_data_d;
  logic [REG_AW-1:0] ex_rd_q,        ex_rd_d;
  logic [XLEN-1:0]   ex_imm_q,       ex_imm_d;
  logic [XLEN-1:0]   ex_pc_q,        ex_pc_d;
  logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic              ex_reg_write_q, ex_reg_write_d;

  logic [XLEN-1:0]   w_ld_rs1_data;
  logic [XLEN-1:0]   w_ld_rs2_data;
  logic [XLEN-1:0]   w_rf_rs1_data;
  logic [XLEN-1:0]   w_rf_rs2_data;
  logic              w_load_use;

  // Operands entering EX from the ID slot.
  wb_bypass_mux u_ld_rs1 (
    .addr_i    (bus.id_rs1_i),
    .rf_data_i (bus.id_rd1_i),
    .wb_we_i   (bus.wb_we_i),
    .wb_rd_i   (bus.wb_rd_i),
    .wb_data_i (bus.wb_data_i),
    .data_o    (w_ld_rs1_data)
  );

  wb_bypass_mux u_ld_rs2 (
    .addr_i    (bus.id_rs2_i),
    .rf_data_i (bus.id_rd2_i),
    .wb_we_i   (bus.wb_we_i),
    .wb_rd_i   (bus.wb_rd_i),
    .wb_data_i (bus.wb_data_i),
    .data_o    (w_ld_rs2_data)
  );

  // Operands already held in EX, refreshed by writebacks while stalled.
  wb_bypass_mux u_rf_rs1 (
    .addr_i    (ex_rs1_q),
    .rf_data_i (ex_rs1_data_q),
    .wb_we_i   (bus.wb_we_i),
    .wb_rd_i   (bus.wb_rd_i),
    .wb_data_i (bus.wb_data_i),
    .data_o    (w_rf_rs1_data)
  );

  wb_bypass_mux u_rf_rs2 (
    .addr_i    (ex_rs2_q),
    .rf_data_i (ex_rs2_data_q),
    .wb_we_i   (bus.wb_we_i),
    .wb_rd_i   (bus.wb_rd_i),
    .wb_data_i (bus.wb_data_i),
    .data_o    (w_rf_rs2_data)
  );

  // A load in EX whose result is consumed by the ID instruction cannot be
  // forwarded in time; rs2 is compared even when the instruction ignores it.
  assign w_load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != REG_X0) &&
                      bus.id_valid_i &&
                      ((ex_rd_q == bus.id_rs1_i) || (ex_rd_q == bus.id_rs2_i));

  // Next EX contents: flush > stall (with refresh) > load-use bubble > load.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rs1_data_d  = ex_rs1_data_q;
    ex_rs2_data_d  = ex_rs2_data_q;
    ex_rd_d        = ex_rd_q;
    ex_imm_d       = ex_imm_q;
    ex_pc_d        = ex_pc_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_reg_write_d = ex_reg_write_q;

    if (bus.flush_i) begin
      ex_valid_d     = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_reg_write_d = 1'b0;
    end else if (bus.stall_i) begin
      ex_rs1_data_d  = w_rf_rs1_data;
      ex_rs2_data_d  = w_rf_rs2_data;
    end else begin
      ex_rs1_d       = bus.id_rs1_i;
      ex_rs2_d       = bus.id_rs2_i;
      ex_rs1_data_d  = w_ld_rs1_data;
      ex_rs2_data_d  = w_ld_rs2_data;
      ex_rd_d        = bus.id_rd_i;
      ex_imm_d       = bus.id_imm_i;
      ex_pc_d        = bus.id_pc_i;
      ex_ctrl_d      = bus.id_ctrl_i;
      // The bubble carries the ID fields but none of the side effects.
      ex_valid_d     = bus.id_valid_i     && !w_load_use;
      ex_mem_read_d  = bus.id_mem_read_i  && !w_load_use;
      ex_reg_write_d = bus.id_reg_write_i && !w_load_use;
    end
  end

  // EX pipeline register; reset empties the slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_rd_q        <= '0;
      ex_imm_q       <= '0;
      ex_pc_q        <= '0;
      ex_ctrl_q      <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      ex_rd_q        <= ex_rd_d;
      ex_imm_q       <= ex_imm_d;
      ex_pc_q        <= ex_pc_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_reg_write_q <= ex_reg_write_d;
    end
  end

  assign bus.ex_valid_o     = ex_valid_q;
  assign bus.ex_rs1_o       = ex_rs1_q;
  assign bus.ex_rs2_o       = ex_rs2_q;
  assign bus.ex_rs1_data_o  = ex_rs1_data_q;
  assign bus.ex_rs2_data_o  = ex_rs2_data_q;
  assign bus.ex_rd_o        = ex_rd_q;
  assign bus.ex_imm_o       = ex_imm_q;
  assign bus.ex_pc_o        = ex_pc_q;
  assign bus.ex_ctrl_o      = ex_ctrl_q;
  assign bus.ex_mem_read_o  = ex_mem_read_q;
  assign bus.ex_reg_write_o = ex_reg_write_q;
  assign bus.load_use_o     = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Self-checking bench for id_ex_stage: directed scenarios with
//           literal expectations plus a behavioural model compared every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_ready = 1'b0;
  bit          m_known = 1'b0;   // data fields defined (not after flush/bubble)
  logic        m_valid, m_mr, m_rw;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc;
  logic [11:0] m_ctrl;

  // Value an instruction sees for register a, given what the regfile returned.
  function automatic logic [31:0] reg_view(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_we_i && bus.wb_rd_i == a) return bus.wb_data_i;
    return rf;
  endfunction

  function automatic logic model_load_use();
    return m_valid && m_mr && (m_rd != 5'd0) && bus.id_valid_i &&
           ((m_rd == bus.id_rs1_i) || (m_rd == bus.id_rs2_i));
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      {m_valid, m_mr, m_rw} = 3'b000;
      {m_rs1, m_rs2, m_rd} = '0;
      {m_d1, m_d2, m_imm, m_pc} = '0;
      m_ctrl  = '0;
      m_known = 1'b1;
      m_ready = 1'b1;
    end else if (bus.flush_i) begin
      {m_valid, m_mr, m_rw} = 3'b000;
      m_known = 1'b0;
    end else if (bus.stall_i) begin
      if (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == m_rs1) m_d1 = bus.wb_data_i;
      if (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == m_rs2) m_d2 = bus.wb_data_i;
    end else if (model_load_use()) begin
      {m_valid, m_mr, m_rw} = 3'b000;
      m_known = 1'b0;
    end else begin
      m_valid = bus.id_valid_i;
      m_mr    = bus.id_mem_read_i;
      m_rw    = bus.id_reg_write_i;
      m_rs1   = bus.id_rs1_i;
      m_rs2   = bus.id_rs2_i;
      m_rd    = bus.id_rd_i;
      m_d1    = reg_view(bus.id_rs1_i, bus.id_rd1_i);
      m_d2    = reg_view(bus.id_rs2_i, bus.id_rd2_i);
      m_imm   = bus.id_imm_i;
      m_pc    = bus.id_pc_i;
      m_ctrl  = bus.id_ctrl_i;
      m_known = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on the falling edge, when outputs and inputs are settled.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("m_valid",     {31'd0, bus.ex_valid_o},     {31'd0, m_valid});
      chk("m_mem_read",  {31'd0, bus.ex_mem_read_o},  {31'd0, m_mr});
      chk("m_reg_write", {31'd0, bus.ex_reg_write_o}, {31'd0, m_rw});
      chk("m_load_use",  {31'd0, bus.load_use_o},     {31'd0, model_load_use()});
      if (m_known) begin
        chk("m_rs1",      {27'd0, bus.ex_rs1_o}, {27'd0, m_rs1});
        chk("m_rs2",      {27'd0, bus.ex_rs2_o}, {27'd0, m_rs2});
        chk("m_rd",       {27'd0, bus.ex_rd_o},  {27'd0, m_rd});
        chk("m_rs1_data", bus.ex_rs1_data_o, m_d1);
        chk("m_rs2_data", bus.ex_rs2_data_o, m_d2);
        chk("m_imm",      bus.ex_imm_o, m_imm);
        chk("m_pc",       bus.ex_pc_o, m_pc);
        chk("m_ctrl",     {20'd0, bus.ex_ctrl_o}, {20'd0, m_ctrl});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] rd1, input logic [31:0] rd2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [31:0] pc, input logic mr,
                          input logic rw);
    bus.id_valid_i     = v;
    bus.id_rs1_i       = rs1;
    bus.id_rs2_i       = rs2;
    bus.id_rd1_i       = rd1;
    bus.id_rd2_i       = rd2;
    bus.id_rd_i        = rd;
    bus.id_imm_i       = imm;
    bus.id_pc_i        = pc;
    bus.id_ctrl_i      = pc[11:0] ^ 12'h5A5;
    bus.id_mem_read_i  = mr;
    bus.id_reg_write_i = rw;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_we_i   = we;
    bus.wb_rd_i   = rd;
    bus.wb_data_i = data;
  endtask

  task automatic randomize_inputs(input bit ctl);
    drive_id($urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 1), $urandom_range(0, 1));
    drive_wb($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
    bus.stall_i = ctl ? ($urandom_range(0, 4) == 0) : 1'b0;
    bus.flush_i = ctl ? ($urandom_range(0, 9) == 0) : 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    randomize_inputs(1'b1);
    tick();
    randomize_inputs(1'b1);
    tick();
    @(negedge clk);
    chk("rst_valid",    {31'd0, bus.ex_valid_o}, 32'd0);
    chk("rst_pc",       bus.ex_pc_o, 32'd0);
    chk("rst_rs1_data", bus.ex_rs1_data_o, 32'd0);
    chk("rst_load_use", {31'd0, bus.load_use_o}, 32'd0);

    // Pass-through
    @(posedge clk); #1;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 5'd3, 5'd4, 32'h3, 32'h44, 5'd10, 32'hFFFF_FFF0, 32'h100, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    chk("pt_rs1_data", bus.ex_rs1_data_o, 32'h3);
    chk("pt_imm",      bus.ex_imm_o, 32'hFFFF_FFF0);
    chk("pt_pc",       bus.ex_pc_o, 32'h100);
    chk("pt_valid",    {31'd0, bus.ex_valid_o}, 32'd1);

    // WB bypass, then x0 override
    @(posedge clk); #1;
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    drive_id(1'b1, 5'd1, 5'd5, 32'h11, 32'h5, 5'd2, 32'd0, 32'h104, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    chk("byp_rs2_data", bus.ex_rs2_data_o, 32'hDEAD_BEEF);
    chk("byp_rs1_data", bus.ex_rs1_data_o, 32'h11);
    @(posedge clk); #1;
    drive_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    drive_id(1'b1, 5'd1, 5'd0, 32'h11, 32'h5, 5'd2, 32'd0, 32'h108, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    chk("x0_rs2_data", bus.ex_rs2_data_o, 32'd0);

    // Load-use hazard
    @(posedge clk); #1;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 5'd7, 32'd4, 32'h10C, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd7, 5'd8, 32'h70, 32'h80, 5'd9, 32'd0, 32'h110, 1'b0, 1'b1);
    @(negedge clk);
    chk("lu_detect", {31'd0, bus.load_use_o}, 32'd1);
    @(negedge clk);
    chk("lu_bubble_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("lu_bubble_lu",    {31'd0, bus.load_use_o}, 32'd0);
    @(negedge clk);
    chk("lu_issue_valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("lu_issue_rd",    {27'd0, bus.ex_rd_o}, 32'd9);
    chk("lu_issue_lu",    {31'd0, bus.load_use_o}, 32'd0);

    // Stall with operand refresh
    @(posedge clk); #1;
    drive_id(1'b1, 5'd9, 5'd6, 32'h55, 32'h66, 5'd12, 32'd8, 32'h200, 1'b0, 1'b1);
    tick();
    bus.stall_i = 1'b1;
    drive_id(1'b1, 5'd2, 5'd3, 32'hAA, 32'hBB, 5'd13, 32'd9, 32'h300, 1'b0, 1'b0);
    tick();
    drive_wb(1'b1, 5'd9, 32'h1234);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("st_rs1_data", bus.ex_rs1_data_o, 32'h1234);
    chk("st_rs2_data", bus.ex_rs2_data_o, 32'h66);
    chk("st_pc",       bus.ex_pc_o, 32'h200);
    chk("st_rs1",      {27'd0, bus.ex_rs1_o}, 32'd9);
    chk("st_valid",    {31'd0, bus.ex_valid_o}, 32'd1);

    // Flush beats stall
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    @(negedge clk);
    chk("fl_valid",     {31'd0, bus.ex_valid_o}, 32'd0);
    chk("fl_reg_write", {31'd0, bus.ex_reg_write_o}, 32'd0);
    chk("fl_mem_read",  {31'd0, bus.ex_mem_read_o}, 32'd0);

    // Reset asserted mid-stall
    @(posedge clk); #1;
    drive_id(1'b1, 5'd4, 5'd5, 32'h4, 32'h5, 5'd6, 32'd1, 32'h400, 1'b1, 1'b1);
    tick();
    bus.stall_i = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.stall_i = 1'b0;
    @(negedge clk);
    chk("rs_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("rs_pc",    bus.ex_pc_o, 32'd0);

    // Mixed traffic checked against the model only
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      randomize_inputs(1'b1);
    end
    @(posedge clk); #1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
